// File: rtl/bram_if_pkg.sv
// Shared widths and FSM state encoding for the trig/done BRAM responder.
package bram_if_pkg;

  localparam int DEFAULT_ADDR_W     = 13;
  localparam int DEFAULT_DATA_W     = 32;
  localparam int DEFAULT_RD_LATENCY = 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    RD_DONE,
    WR_ISSUE,
    WR_DONE
  } state_t;

endpackage

// File: rtl/bram_rd_pipe.sv
// Valid shift register that tracks one BRAM read through the RAM latency.
module bram_rd_pipe #(
  parameter int RD_LATENCY = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  output logic o_capture
);

  logic [RD_LATENCY-1:0] valid_q;
  logic [RD_LATENCY-1:0] valid_d;

  always_comb begin
    valid_d    = valid_q;
    valid_d[0] = i_start;
    for (int i = 1; i < RD_LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign o_capture = valid_q[RD_LATENCY-1];

endmodule

// File: rtl/bram_access_responder.sv
// Serialises one read and one write trig/done request onto a single-port BRAM.
module bram_access_responder
  import bram_if_pkg::*;
#(
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int RD_LATENCY = DEFAULT_RD_LATENCY
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_rd_trig,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_done,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_trig,
  output logic              o_wr_done,
  output logic              o_bram_en,
  output logic              o_bram_we,
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic [DATA_W-1:0] o_bram_wdata,
  input  logic [DATA_W-1:0] i_bram_rdata,
  output logic              o_busy
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_done_pre_q, rd_done_pre_d;
  logic              wr_done_pre_q, wr_done_pre_d;
  logic              rd_capture;

  bram_rd_pipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (state_q == RD_ISSUE),
    .o_capture (rd_capture)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_data_q     <= '0;
      rd_done_pre_q <= 1'b0;
      wr_done_pre_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rd_data_q     <= rd_data_d;
      rd_done_pre_q <= rd_done_pre_d;
      wr_done_pre_q <= wr_done_pre_d;
    end
  end

  // Write wins a tie; a still-high read trig is picked up once back in IDLE.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rd_data_d     = rd_data_q;
    rd_done_pre_d = rd_done_pre_q;
    wr_done_pre_d = wr_done_pre_q;
    case (state_q)
      IDLE: begin
        if (i_wr_trig) begin
          addr_d  = i_wr_addr;
          wdata_d = i_wr_data;
          state_d = WR_ISSUE;
        end else if (i_rd_trig) begin
          addr_d  = i_rd_addr;
          state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        if (rd_capture) begin
          rd_data_d     = i_bram_rdata;
          rd_done_pre_d = 1'b1;
          state_d       = RD_DONE;
        end
      end
      RD_DONE: begin
        if (!i_rd_trig) begin
          rd_done_pre_d = 1'b0;
          state_d       = IDLE;
        end
      end
      WR_ISSUE: begin
        wr_done_pre_d = 1'b1;
        state_d       = WR_DONE;
      end
      WR_DONE: begin
        if (!i_wr_trig) begin
          wr_done_pre_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_bram_en = (state_q == RD_ISSUE) || (state_q == WR_ISSUE);
    o_bram_we = (state_q == WR_ISSUE);
    o_busy    = (state_q != IDLE);
  end

  // Done follows trig combinationally so an aborted request never shows a pulse.
  assign o_rd_done    = rd_done_pre_q & i_rd_trig;
  assign o_wr_done    = wr_done_pre_q & i_wr_trig;
  assign o_rd_data    = rd_data_q;
  assign o_bram_addr  = addr_q;
  assign o_bram_wdata = wdata_q;

endmodule

// File: tb/tb_bram_access_responder.sv
// Drives two responders (read latency 1 and 2) from shared requests against BRAM models and a scoreboard.
module tb_bram_access_responder;

  localparam int AW = 13;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_trig = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_trig = 1'b0;

  logic [DW-1:0] rd_data_a, rd_data_b;
  logic          rd_done_a, rd_done_b, wr_done_a, wr_done_b;
  logic          bram_en_a, bram_en_b, bram_we_a, bram_we_b;
  logic [AW-1:0] bram_addr_a, bram_addr_b;
  logic [DW-1:0] bram_wdata_a, bram_wdata_b;
  logic [DW-1:0] bram_rdata_a = '0;
  logic [DW-1:0] bram_rdata_b = '0;
  logic [DW-1:0] stage_b = '0;
  logic          busy_a, busy_b;

  logic [DW-1:0] ref_mem [0:8191];
  logic [DW-1:0] mem_a   [0:8191];
  logic [DW-1:0] mem_b   [0:8191];

  int total_count = 0;
  int bad_count   = 0;

  always #5 clk = ~clk;

  bram_access_responder #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)) dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_rd_addr(rd_addr), .i_rd_trig(rd_trig), .o_rd_data(rd_data_a), .o_rd_done(rd_done_a),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_trig(wr_trig), .o_wr_done(wr_done_a),
    .o_bram_en(bram_en_a), .o_bram_we(bram_we_a), .o_bram_addr(bram_addr_a),
    .o_bram_wdata(bram_wdata_a), .i_bram_rdata(bram_rdata_a), .o_busy(busy_a)
  );

  bram_access_responder #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(2)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_rd_addr(rd_addr), .i_rd_trig(rd_trig), .o_rd_data(rd_data_b), .o_rd_done(rd_done_b),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_trig(wr_trig), .o_wr_done(wr_done_b),
    .o_bram_en(bram_en_b), .o_bram_we(bram_we_b), .o_bram_addr(bram_addr_b),
    .o_bram_wdata(bram_wdata_b), .i_bram_rdata(bram_rdata_b), .o_busy(busy_b)
  );

  // Native single-port RAMs: plain one-clock read, and an output-registered variant.
  always @(posedge clk) begin
    if (bram_en_a) begin
      if (bram_we_a) mem_a[bram_addr_a] = bram_wdata_a;
      else bram_rdata_a <= mem_a[bram_addr_a];
    end
    if (bram_en_b) begin
      if (bram_we_b) mem_b[bram_addr_b] = bram_wdata_b;
      else stage_b <= mem_b[bram_addr_b];
    end
    bram_rdata_b <= stage_b;
  end

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total_count++;
    if (obs !== exp) begin
      bad_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_addr = a;
    wr_data = d;
    wr_trig = 1'b1;
    next_cycle();
    wr_addr = ~a;
    wr_data = ~d;
    checkOutput("wr_en_a",    32'(bram_en_a), 32'd1);
    checkOutput("wr_we_a",    32'(bram_we_a), 32'd1);
    checkOutput("wr_addr_a",  32'(bram_addr_a), 32'(a));
    checkOutput("wr_wdata_a", bram_wdata_a, d);
    checkOutput("wr_we_b",    32'(bram_we_b), 32'd1);
    checkOutput("wr_early_done_a", 32'(wr_done_a), 32'd0);
    next_cycle();
    checkOutput("wr_done_a",  32'(wr_done_a), 32'd1);
    checkOutput("wr_done_b",  32'(wr_done_b), 32'd1);
    checkOutput("wr_en_off",  32'(bram_en_a), 32'd0);
    checkOutput("wr_we_off",  32'(bram_we_a), 32'd0);
    wr_trig = 1'b0;
    #1;
    checkOutput("wr_done_drop_a", 32'(wr_done_a), 32'd0);
    checkOutput("wr_done_drop_b", 32'(wr_done_b), 32'd0);
    next_cycle();
    checkOutput("wr_idle_a", 32'(busy_a), 32'd0);
    checkOutput("wr_idle_b", 32'(busy_b), 32'd0);
    ref_mem[a] = d;
  endtask

  // Expects rd_trig already high with the address applied; next posedge is the accepting edge.
  task automatic read_phase(input logic [AW-1:0] a);
    logic [DW-1:0] exp;
    exp = ref_mem[a];
    next_cycle();
    rd_addr = ~a;
    checkOutput("rd_en_a",   32'(bram_en_a), 32'd1);
    checkOutput("rd_we_a",   32'(bram_we_a), 32'd0);
    checkOutput("rd_addr_a", 32'(bram_addr_a), 32'(a));
    checkOutput("rd_addr_b", 32'(bram_addr_b), 32'(a));
    next_cycle();
    checkOutput("rd_e1_done_a", 32'(rd_done_a), 32'd0);
    checkOutput("rd_e1_done_b", 32'(rd_done_b), 32'd0);
    next_cycle();
    checkOutput("rd_e2_done_a", 32'(rd_done_a), 32'd1);
    checkOutput("rd_e2_data_a", rd_data_a, exp);
    checkOutput("rd_e2_done_b", 32'(rd_done_b), 32'd0);
    next_cycle();
    checkOutput("rd_hold_done_a", 32'(rd_done_a), 32'd1);
    checkOutput("rd_hold_data_a", rd_data_a, exp);
    checkOutput("rd_e3_done_b",   32'(rd_done_b), 32'd1);
    checkOutput("rd_e3_data_b",   rd_data_b, exp);
    rd_trig = 1'b0;
    #1;
    checkOutput("rd_done_drop_a", 32'(rd_done_a), 32'd0);
    checkOutput("rd_done_drop_b", 32'(rd_done_b), 32'd0);
    next_cycle();
    checkOutput("rd_idle_a", 32'(busy_a), 32'd0);
    checkOutput("rd_idle_b", 32'(busy_b), 32'd0);
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    rd_addr = a;
    rd_trig = 1'b1;
    read_phase(a);
  endtask

  task automatic applyStimulus();
    logic [AW-1:0] a;
    do_write(13'h1FFF, 32'hDEADBEEF);
    do_read(13'h1FFF);

    rd_addr = 13'h0005;
    rd_trig = 1'b1;
    wr_addr = 13'h0005;
    wr_data = 32'h12345678;
    wr_trig = 1'b1;
    next_cycle();
    checkOutput("sim_we_first", 32'(bram_we_a), 32'd1);
    checkOutput("sim_wdata",    bram_wdata_a, 32'h12345678);
    next_cycle();
    checkOutput("sim_wr_done",  32'(wr_done_a), 32'd1);
    checkOutput("sim_rd_wait",  32'(rd_done_a), 32'd0);
    wr_trig = 1'b0;
    next_cycle();
    checkOutput("sim_back_idle", 32'(busy_a), 32'd0);
    ref_mem[13'h0005] = 32'h12345678;
    read_phase(13'h0005);

    rd_addr = 13'h1FFF;
    rd_trig = 1'b1;
    next_cycle();
    rd_trig = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      checkOutput("abort_done_a", 32'(rd_done_a), 32'd0);
      checkOutput("abort_done_b", 32'(rd_done_b), 32'd0);
    end
    checkOutput("abort_idle_a", 32'(busy_a), 32'd0);
    checkOutput("abort_idle_b", 32'(busy_b), 32'd0);

    rd_addr = 13'h1FFF;
    rd_trig = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    rd_trig = 1'b0;
    #1;
    checkOutput("rst_data_a", rd_data_a, 32'd0);
    checkOutput("rst_data_b", rd_data_b, 32'd0);
    checkOutput("rst_busy_a", 32'(busy_a), 32'd0);
    checkOutput("rst_busy_b", 32'(busy_b), 32'd0);
    checkOutput("rst_en_b",   32'(bram_en_b), 32'd0);
    checkOutput("rst_addr_a", 32'(bram_addr_a), 32'd0);
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      checkOutput("post_rst_done_a", 32'(rd_done_a), 32'd0);
      checkOutput("post_rst_done_b", 32'(rd_done_b), 32'd0);
      checkOutput("post_rst_busy_b", 32'(busy_b), 32'd0);
    end

    for (int n = 0; n < 100; n++) begin
      a = ($urandom_range(0, 7) == 0) ? 13'h1FFF : 13'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) do_write(a, $urandom);
      else do_read(a);
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin
      ref_mem[i] = '0;
      mem_a[i]   = '0;
      mem_b[i]   = '0;
    end
    @(negedge clk);
    checkOutput("reset_data",    rd_data_a, 32'd0);
    checkOutput("reset_rd_done", 32'(rd_done_a), 32'd0);
    checkOutput("reset_wr_done", 32'(wr_done_a), 32'd0);
    checkOutput("reset_en",      32'(bram_en_a), 32'd0);
    checkOutput("reset_we",      32'(bram_we_a), 32'd0);
    checkOutput("reset_addr",    32'(bram_addr_a), 32'd0);
    checkOutput("reset_wdata",   bram_wdata_a, 32'd0);
    checkOutput("reset_busy",    32'(busy_b), 32'd0);
    rst = 1'b0;
    next_cycle();
    applyStimulus();
    $display("test done: total=%0d bad=%0d", total_count, bad_count);
    $finish;
  end

endmodule
